// File: rtl/enable_sync_sender_if.sv
// Signal bundle between the upstream word source, the sender and the destination synchronizer.
// The sender takes the slave view; whoever drives words and ack takes the master view.
interface enable_sync_sender_if #(
  parameter int DATA_WIDTH = 5
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  ack;
  logic                  en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;

  modport master (
    output in_valid,
    output in_data,
    output ack,
    input  in_ready,
    input  en,
    input  data_out,
    input  busy,
    input  done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  ack,
    output in_ready,
    output en,
    output data_out,
    output busy,
    output done
  );
endinterface

// File: rtl/enable_sync_sender.sv
// Source-side controller of the enable-based synchronizer: captures a word, holds it on
// data_out, then runs a 4-phase en/ack handshake against a synchronized copy of ack.
module enable_sync_sender #(
  parameter int DATA_WIDTH  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_1,
  input  logic                 rst_n,
  enable_sync_sender_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state_reg;
  logic [SYNC_STAGES-1:0]  ack_sync_reg;
  logic                    ack_s;
  logic                    en_reg;
  logic                    done_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    accept;

  // Raw ack is only ever seen by the first stage of this chain.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], bus.ack};
    end
  end

  assign ack_s  = ack_sync_reg[SYNC_STAGES-1];
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
      data_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            data_reg  <= bus.in_data;
            state_reg <= SETUP;
          end
        end
        // One full cycle of data setup before en; a premature ack cannot hold us here.
        SETUP: begin
          en_reg    <= 1'b1;
          state_reg <= REQ;
        end
        REQ: begin
          if (ack_s) begin
            en_reg    <= 1'b0;
            state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          en_reg    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // A stale high ack from the destination keeps us from starting a new transfer.
  assign bus.in_ready = (state_reg == IDLE) && !ack_s;
  assign bus.en       = en_reg;
  assign bus.data_out = data_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_enable_sync_sender.sv
// Randomized bench for enable_sync_sender: a timestamp model of each transfer predicts every
// output each cycle; a clk_2 receiver closes the loop for the end-to-end run.
module tb_enable_sync_sender;
  localparam int DW   = 5;
  localparam int SS   = 2;
  localparam int NONE = 32'h7fff_ffff;
  localparam int MAXC = 16384;

  logic clk_1 = 1'b0;
  logic clk_2 = 1'b0;
  logic rst_n = 1'b0;

  enable_sync_sender_if #(.DATA_WIDTH(DW)) bus ();

  enable_sync_sender #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk_1 (clk_1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #8 clk_1 = ~clk_1;
  initial begin
    #2;
    forever #4 clk_2 = ~clk_2;
  end

  // stimulus controls
  logic          in_valid_tb = 1'b0;
  logic [DW-1:0] in_data_tb  = '0;
  logic          ack_tb      = 1'b0;
  logic          ack_manual  = 1'b0;
  logic          ack_rx;
  logic          ack_mode    = 1'b0;
  int            ack_kind    = 0;
  int            dly         = 3;
  int            dly_fixed   = 3;
  logic          rand_dly    = 1'b0;
  int            valid_pct   = 100;
  int            offer_target = 0;
  int            acc_count   = 0;
  logic [DW-1:0] dir_q[$];

  assign bus.in_valid = in_valid_tb;
  assign bus.in_data  = in_data_tb;
  assign bus.ack      = ack_mode ? ack_rx : ((ack_kind == 0) ? ack_manual : ack_tb);

  // reference model state: edge numbers of the current transfer's milestones
  int            cyc   = 0;
  logic          ack_at  [MAXC];
  logic          en_hist [MAXC];
  int            acc_e = NONE;
  int            rel_e = NONE;
  int            end_e = NONE;
  logic [DW-1:0] word_m  = '0;
  logic          en_x    = 1'b0;
  logic          busy_x  = 1'b0;
  logic          done_x  = 1'b0;
  logic          ready_x = 1'b1;
  logic [DW-1:0] acc_q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // ack as seen by the block after edge k: the ack sampled SS-1 edges earlier
  function automatic logic ack_s_at(input int k);
    int i;
    i = k - SS + 1;
    if (i < 1) return 1'b0;
    return ack_at[i];
  endfunction

  always @(posedge clk_1 or negedge rst_n) begin
    logic active;
    if (clk_1) begin
      cyc++;
      if (cyc >= MAXC - 1) begin
        $display("FAIL cycle_budget: cycle %0d reached limit %0d", cyc, MAXC);
        $fatal(1);
      end
    end
    if (!rst_n) begin
      if (clk_1) ack_at[cyc] = 1'b0;
      acc_e = NONE; rel_e = NONE; end_e = NONE; word_m = '0;
      en_x = 1'b0; busy_x = 1'b0; done_x = 1'b0; ready_x = 1'b1;
    end else begin
      ack_at[cyc] = bus.ack;
      active = (acc_e != NONE) && (end_e == NONE);
      if (!active) begin
        if (bus.in_valid && !ack_s_at(cyc - 1)) begin
          acc_e = cyc; rel_e = NONE; end_e = NONE;
          word_m = bus.in_data;
          acc_q.push_back(bus.in_data);
          $display("cycle %0d: accepted word %02h", cyc, bus.in_data);
        end
      end else if (rel_e == NONE) begin
        if (cyc >= acc_e + 2 && ack_s_at(cyc - 1)) rel_e = cyc;
      end else if (cyc > rel_e && !ack_s_at(cyc - 1)) begin
        end_e = cyc;
      end
      active  = (acc_e != NONE) && (end_e == NONE);
      busy_x  = active;
      en_x    = active && (cyc >= acc_e + 1) && (rel_e == NONE);
      done_x  = (end_e == cyc);
      ready_x = !active && !ack_s_at(cyc);
    end
    if (clk_1) en_hist[cyc] = en_x;
  end

  // upstream source and ack responder
  always @(posedge clk_1) begin
    #1;
    if (acc_e == cyc) begin
      acc_count++;
      in_valid_tb = 1'b0;
      dly = rand_dly ? int'($urandom_range(1, 4)) : dly_fixed;
    end
    if (!in_valid_tb) begin
      if (acc_count < offer_target && $urandom_range(0, 99) < valid_pct) begin
        in_valid_tb = 1'b1;
        in_data_tb  = (dir_q.size() > 0) ? dir_q.pop_front() : DW'($urandom);
      end else begin
        in_data_tb = DW'($urandom);
      end
    end
    case (ack_kind)
      1: ack_tb = (cyc > dly) ? en_hist[cyc - dly] : 1'b0;
      2: if ($urandom_range(0, 3) == 0) ack_tb = !ack_tb;
      default: ack_tb = 1'b0;
    endcase
  end

  // destination-side enable synchronizer in clk_2
  logic [2:0]    en_sync = 3'b000;
  logic [DW-1:0] rx_q[$];
  assign ack_rx = en_sync[1];
  always @(posedge clk_2) begin
    if (ack_mode && en_sync[1] && !en_sync[2]) rx_q.push_back(bus.data_out);
    en_sync <= {en_sync[1:0], bus.en};
  end

  // per-cycle output checks
  int            en_rises  = 0;
  int            done_seen = 0;
  logic          en_prev   = 1'b0;
  logic [DW-1:0] en_data_q[$];
  always @(negedge clk_1) begin
    chk("en",       32'(bus.en),       32'(en_x));
    chk("busy",     32'(bus.busy),     32'(busy_x));
    chk("done",     32'(bus.done),     32'(done_x));
    chk("in_ready", 32'(bus.in_ready), 32'(ready_x));
    chk("data_out", 32'(bus.data_out), 32'(word_m));
    if (bus.en && !en_prev) begin
      en_rises++;
      en_data_q.push_back(bus.data_out);
    end
    if (bus.done) done_seen++;
    en_prev = bus.en;
  end

  task automatic wait_idle(input int maxc);
    int streak;
    streak = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk_1); #2;
      if (acc_count >= offer_target && !busy_x && !bus.ack && en_sync == 3'b000 && !in_valid_tb)
        streak++;
      else
        streak = 0;
      if (streak >= 4) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_idle: no idle after %0d cycles, busy %0b required 0", maxc, busy_x);
  endtask

  task automatic wait_accept(input int maxc, output int k);
    k = -1;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk_1); #2;
      if (acc_e == cyc) begin
        k = cyc;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_accept: no accept within %0d cycles, got none required 1", maxc);
  endtask

  task automatic wait_offers(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk_1); #2;
      if (acc_count >= offer_target) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_offers: %0d accepted, required %0d", acc_count, offer_target);
  endtask

  initial begin
    int k0;
    int d_edge;
    int base_done;
    int base_en;
    int base_acc;
    int base_cnt;

    repeat (3) @(posedge clk_1);
    #3 rst_n = 1'b1;

    // single transfer with ack driven by hand
    base_done = done_seen;
    ack_kind = 0; valid_pct = 100;
    dir_q.push_back(5'h15);
    offer_target = acc_count + 1;
    wait_accept(20, k0);
    @(posedge clk_1); #2 ack_manual = 1'b1;
    repeat (3) @(posedge clk_1);
    #2 ack_manual = 1'b0;
    wait_idle(40);
    chk("single_done_count", 32'(done_seen - base_done), 32'd1);

    // back-to-back words, ack echoing en three cycles late
    base_done = done_seen; base_en = en_rises;
    rand_dly = 1'b0; dly_fixed = 3; ack_kind = 1;
    dir_q.push_back(5'h01); dir_q.push_back(5'h1E);
    offer_target = acc_count + 2;
    wait_idle(100);
    chk("b2b_en_pulses",   32'(en_rises - base_en),     32'd2);
    chk("b2b_done_pulses", 32'(done_seen - base_done), 32'd2);
    chk("b2b_word0", 32'(en_data_q[base_en]),     32'h01);
    chk("b2b_word1", 32'(en_data_q[base_en + 1]), 32'h1E);

    // stale ack blocks acceptance until the synchronized copy clears
    ack_kind = 0; ack_manual = 1'b1;
    repeat (3) @(posedge clk_1);
    base_cnt = acc_count;
    dir_q.push_back(5'h0A);
    offer_target = acc_count + 1;
    repeat (5) @(posedge clk_1);
    #2;
    chk("stale_no_capture", 32'(acc_count), 32'(base_cnt));
    d_edge = cyc;
    ack_manual = 1'b0;
    wait_accept(20, k0);
    ack_kind = 1;
    chk("stale_accept_edge", 32'(k0), 32'(d_edge + SS + 1));
    wait_idle(60);

    // stall: ack stays low for 50 cycles after en rises, second word must wait
    dly_fixed = 50;
    offer_target = acc_count + 2;
    wait_idle(400);

    // random words with random ack latency
    rand_dly = 1'b1; valid_pct = 70;
    offer_target = acc_count + 40;
    wait_idle(2000);

    // ack noise, including ack rising in IDLE and SETUP
    ack_kind = 2; valid_pct = 60;
    offer_target = acc_count + 30;
    wait_offers(3000);
    ack_kind = 1;
    wait_idle(200);

    // asynchronous reset while en is high
    rand_dly = 1'b0; dly_fixed = 3; valid_pct = 100;
    dir_q.push_back(5'h0B);
    offer_target = acc_count + 1;
    for (int i = 0; i < 20 && !en_x; i++) begin
      @(posedge clk_1); #2;
    end
    chk("pre_reset_en", 32'(bus.en), 32'd1);
    @(negedge clk_1); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_en",       32'(bus.en),       32'd0);
    chk("async_rst_data_out", 32'(bus.data_out), 32'd0);
    chk("async_rst_busy",     32'(bus.busy),     32'd0);
    chk("async_rst_done",     32'(bus.done),     32'd0);
    repeat (3) @(posedge clk_1);
    #3 rst_n = 1'b1;
    base_done = done_seen;
    dir_q.push_back(5'h13);
    offer_target = acc_count + 1;
    wait_idle(80);
    chk("post_rst_done",     32'(done_seen - base_done), 32'd1);
    chk("post_rst_data_out", 32'(bus.data_out),          32'h13);

    // end-to-end with the clk_2 receiver supplying ack
    ack_mode = 1'b1; valid_pct = 80;
    base_acc = acc_q.size();
    offer_target = acc_count + 20;
    wait_idle(1500);
    chk("e2e_count", 32'(rx_q.size()), 32'd20);
    for (int i = 0; i < 20 && i < rx_q.size(); i++)
      chk("e2e_word", 32'(rx_q[i]), 32'(acc_q[base_acc + i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
